// File: rtl/shift_add_mult_pkg.sv
// ============================================================================
// shift_add_mult_pkg : shared FSM encoding for the shift-and-add multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_add_mult_add.sv
// ============================================================================
// add : N-bit ripple-carry adder (one full adder per bit)
// Revision 1.0
// ============================================================================
`default_nettype none

module add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic w_p;
    assign w_p          = a_i[i] ^ b_i[i];
    assign sum_o[i]     = w_p ^ w_carry[i];
    assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & w_p);
  end

  assign cout_o = w_carry[N];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult.sv
// ============================================================================
// shift_add_mult : sequential unsigned NxN shift-and-add multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int              CNT_W  = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     mq_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*N-1:0]   product_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;
  logic             w_cout;
  logic [2*N-1:0]   w_shift_d;

  assign w_addend = mq_q[0] ? mcand_q : '0;

  add #(.N(N)) u_add (
    .a_i    (acc_q),
    .b_i    (w_addend),
    .cin_i  (1'b0),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  // {cout,sum,mq} >> 1 : carry lands in the accumulator MSB, never lost
  assign w_shift_d = {w_cout, w_sum, mq_q[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            mq_q    <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= w_shift_d[2*N-1:N];
          mq_q  <= w_shift_d[N-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == c_last) begin
            product_q <= w_shift_d;
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult.sv
// ============================================================================
// tb_shift_add_mult : checks N=4 and N=8 multipliers against a*b
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_shift_add_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int n_cmp = 0;
  int n_bad = 0;

  shift_add_mult #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_mult #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_busy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction

  function automatic logic sel_done(input bit wide);
    return wide ? done8 : done4;
  endfunction

  function automatic logic [15:0] sel_prod(input bit wide);
    return wide ? prod8 : {8'h00, prod4};
  endfunction

  // Count edges from the accepting edge until done shows, bounded.
  task automatic wait_done(input bit wide, input string tag, input int unsigned exp_prod);
    int n   = wide ? 8 : 4;
    int lat = 1;
    while (!sel_done(wide) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(n + 1));
    check({tag, "_prod"}, 64'(sel_prod(wide)), 64'(exp_prod));
    check({tag, "_busy_in_done"}, 64'(sel_busy(wide)), 64'd0);
  endtask

  task automatic mul(input bit wide, input int unsigned x, input int unsigned y, input string tag);
    int unsigned exp_prod = x * y;
    @(negedge clk);
    if (wide) begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    else      begin a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    check({tag, "_busy"}, 64'(sel_busy(wide)), 64'd1);
    wait_done(wide, tag, exp_prod);
    @(negedge clk);
    check({tag, "_idle_done"}, 64'(sel_done(wide)), 64'd0);
    check({tag, "_idle_busy"}, 64'(sel_busy(wide)), 64'd0);
    check({tag, "_hold"}, 64'(sel_prod(wide)), 64'(exp_prod));
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_prod4", 64'(prod4), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);
    rst = 1'b0;

    mul(1'b0, 3, 5, "m3x5");
    mul(1'b0, 15, 15, "m15x15");
    mul(1'b0, 0, 9, "m0x9");
    mul(1'b0, 9, 0, "m9x0");

    // start held high with operands changing after capture
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7;
    check("held_busy", 64'(busy4), 64'd1);
    wait_done(1'b0, "held1", 15);
    @(negedge clk);
    check("held_gap_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    start4 = 1'b0;
    check("held_restart", 64'(busy4), 64'd1);
    wait_done(1'b0, "held2", 49);
    @(negedge clk);

    // asynchronous reset in the middle of iteration 2
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd11; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_prod", 64'(prod4), 64'd0);
    check("mid_rst_busy", 64'(busy4), 64'd0);
    check("mid_rst_done", 64'(done4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mul(1'b0, 6, 7, "m6x7");

    mul(1'b1, 255, 255, "w255x255");
    for (int i = 0; i < 1000; i++) begin
      mul(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), "rand8");
    end
    for (int i = 0; i < 100; i++) begin
      mul(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), "rand4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
Sequential unsigned N x N multiplier using the shift-and-add method. It is the control and datapath stage that sits directly upstream of the team's `add` ripple-carry adder. Each cycle it feeds one partial-product addition to a single `add #(N)` instance and registers that instance's sum and cout. It gives the lab a multi-cycle arithmetic unit with a start/busy/done handshake.

Parameters:
- N, 4, operand width in bits; N >= 2. Product width is 2N.

Ports:
- clk  input  1  single clock; all flops update on its rising edge.
- rst  input  1  reset; asynchronous, active-high. Asserting it clears all state immediately; release is taken on a clk edge.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  N  multiplicand; captured on the accepted start edge.
- b  input  N  multiplier; captured on the accepted start edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2N  registered result; holds its value until the next completion or reset.

Behaviour:
- Registers:
  - mcand[N-1:0], multiplicand.
  - acc[N-1:0], upper half of the partial product.
  - mq[N-1:0], multiplier, becomes the lower half.
  - cnt, width $clog2(N)+1.
  - state.
  - product[2N-1:0].
- Reset values: state=IDLE; busy=0; done=0; product=0; acc=0; mq=0; mcand=0; cnt=0.
- FSM states: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - If start=1 at edge E0: mcand<=a, mq<=b, acc<=0, cnt<=0, state<=CALC.
  - If start=0: stay in IDLE; all registers hold.
- CALC (edges E1..EN, one iteration per edge):
  - Adder inputs: add.a=acc, add.b = mq[0] ? mcand : 0, add.cin=0.
  - Update: {acc,mq} <= {cout,sum,mq} >> 1. That is, acc <= {cout,sum[N-1:1]} and mq <= {sum[0],mq[N-1:1]}.
  - cnt <= cnt+1.
  - On the edge where cnt==N-1 (edge EN): product <= {cout,sum,mq} >> 1 (the same shifted value), and state<=DONE.
- DONE: lasts exactly one cycle; done=1 during it. At edge EN+1: state<=IDLE.
- Latency:
  - done is high in the cycle following edge EN, i.e. N+1 edges after start was sampled.
  - Next start is accepted no earlier than edge EN+2, giving a throughput of one multiply per N+2 cycles.
- Ignored inputs:
  - start in CALC or DONE is ignored and is not queued.
  - a and b are don't-care after the accepting edge.
- Width rule: the adder's cout is never discarded; it becomes acc's MSB after the shift. The result is exact for all unsigned inputs, including (2^N-1)^2.
- Zero operands need no special case: all N iterations run, and product=0.
- Reset mid-operation: immediate return to IDLE, outputs go to their reset values, and the in-flight result is lost.
- start held high continuously: a new operation starts every N+2 cycles.

Decomposition:
- Shared package holds the FSM state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- Counter width is derived locally.
- One sub-module: the existing `add #(.N(N))` instance. It is the only adder; do not write an inline `+`.
- The FSM and shift registers stay in shift_add_mult.

Test Plan:
- N=4, a=3, b=5, start pulse → busy high for 4 cycles, then done for 1 cycle with product=8'h0F; afterwards busy=done=0.
- N=4, a=15, b=15 → product=8'hE1 (225). Check that cout propagates into the upper half.
- N=4, a=0, b=9, then a=9, b=0 → product=0 both times, each with latency 5 edges.
- N=4, start held high through CALC with a and b changed mid-operation → the first result reflects the captured operands; a new operation begins only after DONE.
- rst asserted during CALC iteration 2 (between clock edges) → product=0, busy=0, done=0 immediately. After release, 6*7 yields product=8'h2A.
- N=8, a=255, b=255 → product=16'hFE01 after 9 edges. Then random operands over 1000 runs are checked against a reference product.
